// File: rtl/dma_frame_writer.sv
// dma_frame_writer
//   Decimates a free-running sample stream into a small FIFO and streams one
//   fixed-length frame per request over an AXI4-Stream master. The FIFO is
//   fronted by a first-word fall-through output register.
//
//   Optional feature: define DMA_FRAME_WRITER_HEADER_EN to precede every frame
//   with a header beat {16'hD0D0, 6'd0, D[25:0], frame_count[15:0]}.
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   enable_i             frame request level (sampled in IDLE and DONE only)
//   data_i               sample word, valid every cycle
//   decimation_code_i    decimation factor D (0 behaves as 1), latched per frame
//   m_axis_t*            AXI4-Stream master (tdata/tvalid/tready/tlast)
//   engaged_o            frame in progress (CAPTURE or DRAIN)
//   finished_o           frame complete, held until enable_i falls
//   overflow_o           sticky: a due sample was dropped this frame
module dma_frame_writer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEC_WIDTH  = 26,
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DEC_WIDTH-1:0]  decimation_code_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  engaged_o,
  output logic                  finished_o,
  output logic                  overflow_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [DEC_WIDTH-1:0]   dec_q, dec_d;
  logic [DEC_WIDTH-1:0]   dec_cnt_q, dec_cnt_d;
  logic [CW-1:0]          sample_cnt_q, sample_cnt_d;
  logic                   overflow_q, overflow_d;

  // FIFO entries and output register hold {tlast, data}
  logic [DATA_WIDTH:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH:0]    out_q, out_d;

  logic                   push;
  logic [DATA_WIDTH:0]    push_entry;
  logic                   pop;
  logic                   out_load;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   fifo_wr;
  logic                   fifo_rd;

`ifdef DMA_FRAME_WRITER_HEADER_EN
  logic                   hdr_q, hdr_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic [63:0]            header;
  assign header = {16'hD0D0, 6'd0, 26'(dec_q), frame_cnt_q};
`endif

  assign pop        = out_valid_q & m_axis_tready;
  assign out_load   = ~out_valid_q | pop;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));

  // Frame FSM, decimation and push decision
  always_comb begin
    state_d      = state_q;
    dec_d        = dec_q;
    dec_cnt_d    = dec_cnt_q;
    sample_cnt_d = sample_cnt_q;
    overflow_d   = overflow_q;
    push         = 1'b0;
    push_entry   = '0;
`ifdef DMA_FRAME_WRITER_HEADER_EN
    hdr_d        = hdr_q;
    frame_cnt_d  = frame_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d      = CAPTURE;
          dec_d        = (decimation_code_i == '0) ? DEC_WIDTH'(1) : decimation_code_i;
          dec_cnt_d    = '0;
          sample_cnt_d = '0;
          overflow_d   = 1'b0;
`ifdef DMA_FRAME_WRITER_HEADER_EN
          hdr_d        = 1'b1;
`endif
        end
      end
      CAPTURE: begin
`ifdef DMA_FRAME_WRITER_HEADER_EN
        // Header takes the first slot; dec_cnt holds so the first sample
        // slides by exactly one cycle.
        if (hdr_q) begin
          push       = 1'b1;
          push_entry = {1'b0, DATA_WIDTH'(header)};
          hdr_d      = 1'b0;
        end else
`endif
        begin
          dec_cnt_d = (dec_cnt_q == dec_q - 1'b1) ? '0 : dec_cnt_q + 1'b1;
          if (dec_cnt_q == '0) begin
            // Full only when both FIFO and output register are occupied and
            // nothing leaves this cycle.
            if (fifo_full && !out_load) begin
              overflow_d = 1'b1;
            end else begin
              push         = 1'b1;
              push_entry   = {sample_cnt_q == CW'(FRAME_LEN - 1), data_i};
              sample_cnt_d = sample_cnt_q + 1'b1;
              if (sample_cnt_q == CW'(FRAME_LEN - 1)) state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (pop && out_q[DATA_WIDTH]) begin
          state_d = DONE;
`ifdef DMA_FRAME_WRITER_HEADER_EN
          frame_cnt_d = frame_cnt_q + 16'd1;
`endif
        end
      end
      DONE: begin
        if (!enable_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO plus fall-through output register; a push bypasses the FIFO when the
  // output register is free and the FIFO is empty.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    fifo_rd     = out_load & ~fifo_empty;
    fifo_wr     = push & ~(out_load & fifo_empty);
    if (out_load) begin
      if (!fifo_empty) begin
        out_valid_d = 1'b1;
        out_d       = mem_q[rd_ptr_q];
      end else if (push) begin
        out_valid_d = 1'b1;
        out_d       = push_entry;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    wr_ptr_d = wr_ptr_q + AW'(fifo_wr);
    rd_ptr_d = rd_ptr_q + AW'(fifo_rd);
    count_d  = count_q + (AW+1)'(fifo_wr) - (AW+1)'(fifo_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dec_q        <= DEC_WIDTH'(1);
      dec_cnt_q    <= '0;
      sample_cnt_q <= '0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
`ifdef DMA_FRAME_WRITER_HEADER_EN
      hdr_q        <= 1'b0;
      frame_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dec_q        <= dec_d;
      dec_cnt_q    <= dec_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
`ifdef DMA_FRAME_WRITER_HEADER_EN
      hdr_q        <= hdr_d;
      frame_cnt_q  <= frame_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= push_entry;
  end

  assign m_axis_tdata  = out_q[DATA_WIDTH-1:0];
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_valid_q & out_q[DATA_WIDTH];
  assign engaged_o     = (state_q == CAPTURE) || (state_q == DRAIN);
  assign finished_o    = (state_q == DONE);
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_dma_frame_writer.sv
`timescale 1ns/1ps
module tb_dma_frame_writer;
  localparam int DW  = 64;
  localparam int FL  = 8;
  localparam int FD  = 4;
  localparam int BFL = 64;
  localparam int BFD = 16;
`ifdef DMA_FRAME_WRITER_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance: short frames, shallow FIFO
  logic a_rst, a_en, a_tready, a_tvalid, a_tlast, a_engaged, a_finished, a_overflow;
  logic [DW-1:0] a_data, a_tdata;
  logic [25:0]   a_code;
  // backpressure instance
  logic b_rst, b_en, b_tready, b_tvalid, b_tlast, b_engaged, b_finished, b_overflow;
  logic [DW-1:0] b_data, b_tdata;
  logic [25:0]   b_code;

  dma_frame_writer #(.DATA_WIDTH(DW), .DEC_WIDTH(26), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) u_a (
    .clk(clk), .rst(a_rst), .enable_i(a_en), .data_i(a_data), .decimation_code_i(a_code),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
    .m_axis_tlast(a_tlast), .engaged_o(a_engaged), .finished_o(a_finished),
    .overflow_o(a_overflow));

  dma_frame_writer #(.DATA_WIDTH(DW), .DEC_WIDTH(26), .FRAME_LEN(BFL), .FIFO_DEPTH(BFD)) u_b (
    .clk(clk), .rst(b_rst), .enable_i(b_en), .data_i(b_data), .decimation_code_i(b_code),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
    .m_axis_tlast(b_tlast), .engaged_o(b_engaged), .finished_o(b_finished),
    .overflow_o(b_overflow));

  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference model state for the main instance
  logic [DW:0]     mq[$];      // entries the DUT should be holding, {last, data}
  logic [DW-1:0]   got_q[$];   // beats handed over this frame
  bit              ovf_exp = 1'b0;
  int unsigned     fcnt_exp = 0;
  longint unsigned last_t0 = 0;

  typedef struct {
    logic [25:0] code;
    int          step;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] header_exp(input int unsigned d, input int unsigned fc);
    return {16'hD0D0, 6'd0, d[25:0], fc[15:0]};
  endfunction

  // One frame on the main instance, checked cycle by cycle against a queue
  // model: samples are due every D cycles from the first CAPTURE cycle, and a
  // due sample is kept only if fewer than FD+1 entries remain after any pop.
  task automatic run_frame(input logic [25:0] code, input int rdy_pct, input int hold_low,
                           input bit rnd_data, input int abort_at, input int done_hold);
    int d, t, accepted, occ;
    bit done, r, pop;
    logic [DW-1:0] x;
    logic [DW:0] e;
    d = (code == 0) ? 1 : int'(code);
    check("idle_engaged", a_engaged, 0);
    check("idle_finished", a_finished, 0);
    check("idle_tvalid", a_tvalid, 0);
    check("idle_overflow_sticky", a_overflow, ovf_exp);
    a_en = 1'b1; a_code = code; a_tready = 1'b0; a_data = DW'(cyc);
    last_t0 = cyc;
    mq.delete(); got_q.delete();
    ovf_exp = 1'b0; accepted = 0; done = 1'b0;
    for (t = 1; t <= 3000 && !done; t++) begin
      tick();
      check("engaged", a_engaged, 1);
      check("finished_mid", a_finished, 0);
      check("tvalid", a_tvalid, mq.size() > 0);
      if (mq.size() > 0) check("tdata", a_tdata, mq[0][DW-1:0]);
      check("tlast", a_tlast, (mq.size() > 0) && mq[0][DW]);
      check("overflow", a_overflow, ovf_exp);
      if (t == abort_at) begin
        a_rst = 1'b1; a_en = 1'b0;
        tick();
        check("abort_tvalid", a_tvalid, 0);
        check("abort_engaged", a_engaged, 0);
        check("abort_finished", a_finished, 0);
        check("abort_overflow", a_overflow, 0);
        a_rst = 1'b0;
        ovf_exp = 1'b0; fcnt_exp = 0;
        return;
      end
      r = (t < hold_low) ? 1'b0 : ($urandom_range(1, 100) <= rdy_pct);
      x = rnd_data ? {$urandom, $urandom} : DW'(cyc);
      a_tready = r; a_data = x;
      a_en   = 1'($urandom_range(0, 1));
      a_code = 26'($urandom);
      pop = (mq.size() > 0) && r;
      if (HDR != 0 && t == 1) begin
        mq.push_back({1'b0, header_exp(d, fcnt_exp)});
      end else if (accepted < FL && ((t - 1 - HDR) % d) == 0) begin
        occ = mq.size();
        if (pop) occ--;
        if (occ < FD + 1) begin
          mq.push_back({accepted == FL - 1, x});
          accepted++;
        end else begin
          ovf_exp = 1'b1;
        end
      end
      if (pop) begin
        e = mq.pop_front();
        got_q.push_back(e[DW-1:0]);
        if (e[DW]) done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL frame_timeout: got %0d beats, expected %0d", got_q.size(), FL + HDR);
    end
    tick();
    check("done_finished", a_finished, 1);
    check("done_engaged", a_engaged, 0);
    check("done_tvalid", a_tvalid, 0);
    check("done_overflow", a_overflow, ovf_exp);
    fcnt_exp = (fcnt_exp + 1) & 32'hFFFF;
    for (int i = 0; i < done_hold; i++) begin
      a_en = 1'b1;
      tick();
      check("rearm_hold_finished", a_finished, 1);
      check("rearm_hold_engaged", a_engaged, 0);
      check("rearm_hold_tvalid", a_tvalid, 0);
    end
    a_en = 1'b0;
    tick();
    check("release_finished", a_finished, 0);
    check("release_engaged", a_engaged, 0);
  endtask

  initial begin
    int nbeats, k;
    bit bdone, prev_stall, rdy;
    logic [DW-1:0] prev, bexp;

    vecs[0] = '{26'd5, 5};
    vecs[1] = '{26'd1, 1};
    vecs[2] = '{26'd4, 4};
    vecs[3] = '{26'd0, 1};
    vecs[4] = '{26'd3, 3};

    a_rst = 1'b1; a_en = 1'b0; a_data = '0; a_code = '0; a_tready = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_data = '0; b_code = '0; b_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_tvalid", a_tvalid, 0);
    check("rst_a_tlast", a_tlast, 0);
    check("rst_a_tdata", a_tdata, 0);
    check("rst_a_engaged", a_engaged, 0);
    check("rst_a_finished", a_finished, 0);
    check("rst_a_overflow", a_overflow, 0);
    check("rst_b_tvalid", b_tvalid, 0);
    check("rst_b_engaged", b_engaged, 0);
    a_rst = 1'b0; b_rst = 1'b0;
    tick();

    // table-driven frames: full-rate ready, beat k carries the sample at
    // cycle t0 + 1 + HDR + k*D
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].code, 100, 0, 1'b0, 0, 0);
      check("vec_beats", got_q.size(), FL + HDR);
      for (int j = 0; j < FL && (j + HDR) < got_q.size(); j++)
        check("vec_data", got_q[j + HDR], last_t0 + 1 + HDR + j * vecs[i].step);
      check("vec_overflow", a_overflow, 0);
`ifdef DMA_FRAME_WRITER_HEADER_EN
      if (i == 0) check("hdr_first", got_q[0], 64'hD0D0_0000_0005_0000);
      if (i == 1) check("hdr_second", got_q[0], 64'hD0D0_0000_0001_0001);
`endif
    end

    // forced overflow, then enable held high in DONE: no new frame
    run_frame(26'd1, 100, 15, 1'b1, 0, 4);
    check("ovf_sticky_idle", a_overflow, 1);
    check("ovf_beats", got_q.size(), FL + HDR);
    // rearm after a one-cycle low: overflow clears on frame start
    run_frame(26'd2, 100, 0, 1'b1, 0, 0);
    check("rearm_overflow", a_overflow, 0);

    // reset at sample 3, then a clean frame
    run_frame(26'd1, 100, 0, 1'b0, 3 + HDR, 0);
    run_frame(26'd1, 100, 0, 1'b0, 0, 0);
    check("post_abort_beats", got_q.size(), FL + HDR);
    check("post_abort_first", got_q[HDR], last_t0 + 1 + HDR);

    // randomized frames against the queue model
    for (int i = 0; i < 20; i++)
      run_frame(26'($urandom_range(0, 6)), $urandom_range(30, 100),
                $urandom_range(0, 10), 1'b1, 0, $urandom_range(0, 2));

    // backpressure on the 64/16 instance: tready low for cycles 0..39.
    // Output register plus 16 FIFO entries fill by cycle 17, samples 18..39
    // are dropped, and the stream resumes with the sample at cycle 40.
    b_en = 1'b1; b_code = 26'd1; b_tready = 1'b0; b_data = '0;
    nbeats = 0; bdone = 1'b0; prev_stall = 1'b0; prev = '0;
    for (int c = 1; c < 400 && !bdone; c++) begin
      tick();
      if (prev_stall) check("bp_stable_tdata", b_tdata, prev);
      rdy = (c >= 40);
      b_tready = rdy; b_data = DW'(c); b_en = 1'b0;
      if (b_tvalid && rdy) begin
        k = nbeats - HDR;
`ifdef DMA_FRAME_WRITER_HEADER_EN
        if (nbeats == 0) check("bp_header", b_tdata, 64'hD0D0_0000_0001_0000);
`endif
        if (k >= 0) begin
          bexp = (k < 17 - HDR) ? DW'(1 + HDR + k) : DW'(40 + k - (17 - HDR));
          check("bp_tdata", b_tdata, bexp);
        end
        check("bp_tlast", b_tlast, nbeats == BFL + HDR - 1);
        if (b_tlast) bdone = 1'b1;
        nbeats++;
      end
      prev_stall = b_tvalid && !rdy;
      prev = b_tdata;
    end
    if (!bdone) begin
      checks++; errors++;
      $display("FAIL bp_timeout: got %0d beats, expected %0d", nbeats, BFL + HDR);
    end
    check("bp_beats", nbeats, BFL + HDR);
    check("bp_overflow", b_overflow, 1);
    tick();
    check("bp_finished", b_finished, 1);
    check("bp_engaged", b_engaged, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
